dn_loader_ctrl: RTL and testbench

//  Sequences ioctl ROM/RAM download bytes into the shared core memory port and

---
 rtl/dn_loader_ctrl.sv | 154 +++++++++++++++
 tb/tb_dn_loader_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dn_loader_ctrl.sv
// Download sequencer: moves ioctl bytes through a one-entry buffer onto the shared
// memory port, arbitrates that port with the CPU and holds the core in reset while loading.
module dn_loader_ctrl #(
   parameter int         ADDR_W   = 14,
   parameter int         DATA_W   = 8,
   parameter logic [7:0] DN_INDEX = 8'd0,
   parameter int         POST_RST = 16
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              ioctl_download,
   input  logic              ioctl_wr,
   input  logic [24:0]       ioctl_addr,
   input  logic [DATA_W-1:0] ioctl_dout,
   input  logic [7:0]        ioctl_index,
   output logic              ioctl_wait,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_din,
   output logic              cpu_ack,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   input  logic              mem_ready,
   output logic              core_reset,
   output logic [ADDR_W:0]   dn_count,
   output logic              dn_err
);

   localparam int CNT_W = $clog2(POST_RST + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_LOAD_IGN,
      S_HOLD,
      S_RUN
   } state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic                r_dl_prev;
   logic                r_buf_full;
   logic [ADDR_W-1:0]   r_buf_addr;
   logic [DATA_W-1:0]   r_buf_data;
   logic [CNT_W-1:0]    r_hold_cnt;
   logic [ADDR_W:0]     r_dn_count;
   logic                r_dn_err;
   logic                r_cpu_busy;
   logic                r_cpu_ack;

   logic                w_rise;
   logic                w_match;
   logic                w_addr_ok;
   logic                w_cpu_go;
   logic                w_buf_done;
   logic                w_wr_live;
   logic                w_cap;
   logic                w_bad;
   logic                w_start;
   logic                w_enter_hold;

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_rise       = ioctl_download & ~r_dl_prev;
      w_match      = (ioctl_index == DN_INDEX);
      w_addr_ok    = ((ioctl_addr >> ADDR_W) == 25'd0);
      w_state_next = r_state;
      case (r_state)
         S_IDLE:     if (w_rise) w_state_next = w_match ? S_LOAD : S_LOAD_IGN;
         S_LOAD:     if (!ioctl_download && !r_buf_full) w_state_next = S_HOLD;
         S_LOAD_IGN: if (!ioctl_download) w_state_next = S_HOLD;
         S_HOLD:     if (r_hold_cnt <= CNT_W'(1)) w_state_next = S_RUN;
         S_RUN:      if (w_rise && w_match) w_state_next = S_LOAD;
         default:    w_state_next = S_IDLE;
      endcase
      w_start      = (w_state_next == S_LOAD) && (r_state != S_LOAD);
      w_enter_hold = (w_state_next == S_HOLD) && (r_state != S_HOLD);

      // A CPU access that was presented but not yet accepted keeps the port,
      // even if a download started meanwhile; a fresh request loses to a download rise.
      w_cpu_go   = r_cpu_busy |
                   ((r_state == S_RUN) & cpu_req & ~r_cpu_ack & ~(w_rise & w_match));
      w_buf_done = r_buf_full & ~w_cpu_go & mem_ready;

      w_wr_live = (r_state == S_LOAD) & ioctl_wr & ioctl_download;
      w_cap     = w_wr_live & ~r_buf_full & w_addr_ok;
      w_bad     = w_wr_live & ~w_cap;

      mem_en   = 1'b0;
      mem_we   = 1'b0;
      mem_addr = '0;
      mem_din  = '0;
      if (w_cpu_go) begin
         mem_en   = 1'b1;
         mem_we   = cpu_we;
         mem_addr = cpu_addr;
         mem_din  = cpu_din;
      end else if (r_buf_full) begin
         mem_en   = 1'b1;
         mem_we   = 1'b1;
         mem_addr = r_buf_addr;
         mem_din  = r_buf_data;
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         r_dl_prev  <= 1'b0;
         r_buf_full <= 1'b0;
         r_buf_addr <= '0;
         r_buf_data <= '0;
         r_hold_cnt <= CNT_W'(POST_RST);
         r_dn_count <= '0;
         r_dn_err   <= 1'b0;
         r_cpu_busy <= 1'b0;
         r_cpu_ack  <= 1'b0;
      end else begin
         r_dl_prev  <= ioctl_download;
         r_cpu_busy <= w_cpu_go & ~mem_ready;
         r_cpu_ack  <= w_cpu_go & mem_ready;

         if (w_cap) begin
            r_buf_full <= 1'b1;
            r_buf_addr <= ioctl_addr[ADDR_W-1:0];
            r_buf_data <= ioctl_dout;
         end else if (w_buf_done) begin
            r_buf_full <= 1'b0;
         end

         if (w_enter_hold)           r_hold_cnt <= CNT_W'(POST_RST);
         else if (r_state == S_HOLD) r_hold_cnt <= r_hold_cnt - CNT_W'(1);

         if (w_start)                           r_dn_count <= '0;
         else if (w_buf_done && ~&r_dn_count)   r_dn_count <= r_dn_count + 1'b1;

         if (w_start)    r_dn_err <= 1'b0;
         else if (w_bad) r_dn_err <= 1'b1;
      end
   end

   assign ioctl_wait = r_buf_full;
   assign cpu_ack    = r_cpu_ack;
   assign core_reset = (r_state != S_RUN);
   assign dn_count   = r_dn_count;
   assign dn_err     = r_dn_err;

endmodule

// File: tb/tb_dn_loader_ctrl.sv
// Directed bench for dn_loader_ctrl: expected memory writes are queued by the
// stimulus and retired by a monitor that watches accepted memory strobes.
module tb_dn_loader_ctrl;
   localparam int ADDR_W = 14;
   localparam int DATA_W = 8;

   logic              clk_sys = 1'b0;
   logic              reset;
   logic              ioctl_download;
   logic              ioctl_wr;
   logic [24:0]       ioctl_addr;
   logic [DATA_W-1:0] ioctl_dout;
   logic [7:0]        ioctl_index;
   logic              ioctl_wait;
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_din;
   logic              cpu_ack;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_din;
   logic              mem_ready;
   logic              core_reset;
   logic [ADDR_W:0]   dn_count;
   logic              dn_err;

   int checks = 0;
   int errors = 0;
   logic [ADDR_W+DATA_W:0] exp_q[$];

   always #5 clk_sys = ~clk_sys;

   dn_loader_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DN_INDEX(8'd0), .POST_RST(16)) dut (
      .clk_sys(clk_sys), .reset(reset),
      .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
      .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index), .ioctl_wait(ioctl_wait),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
      .cpu_ack(cpu_ack), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_din(mem_din), .mem_ready(mem_ready), .core_reset(core_reset),
      .dn_count(dn_count), .dn_err(dn_err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end else begin
         $display("check %s = %0h ok", name, act);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic send_byte(input logic [24:0] a, input logic [7:0] d, input int rdy_at,
                            output int n);
      ioctl_addr = a;
      ioctl_dout = d;
      ioctl_wr   = 1'b1;
      tick();
      ioctl_wr = 1'b0;
      n = 0;
      while (ioctl_wait && n < 100) begin
         n++;
         if (n == rdy_at) mem_ready = 1'b1;
         tick();
      end
      mem_ready = 1'b1;
   endtask

   task automatic wait_run(output int k);
      k = 0;
      while (core_reset && k < 200) begin
         tick();
         k++;
      end
   endtask

   // Monitor: every strobe the memory accepts must match the oldest expected write.
   initial begin
      logic [ADDR_W+DATA_W:0] got;
      logic [ADDR_W+DATA_W:0] e;
      forever begin
         @(negedge clk_sys);
         if (!reset && mem_en && mem_ready) begin
            got = {mem_we, mem_addr, mem_din};
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL mem_write unexpected actual=%0h required=none", got);
            end else begin
               e = exp_q.pop_front();
               if (got !== e) begin
                  errors++;
                  $display("FAIL mem_write actual=%0h required=%0h", got, e);
               end else begin
                  $display("mem write we=%0b addr=%0h data=%0h ok", mem_we, mem_addr, mem_din);
               end
            end
         end
      end
   end

   initial begin
      int n;
      int k;
      int bad;
      int acks;
      int pre_ack;

      reset = 1'b1;
      ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = '0;
      ioctl_index = 8'd0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
      mem_ready = 1'b1;
      #2;
      chk("rst_core_reset", core_reset, 1);
      chk("rst_ioctl_wait", ioctl_wait, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_cpu_ack", cpu_ack, 0);
      chk("rst_dn_count", dn_count, 0);
      chk("rst_dn_err", dn_err, 0);
      tick(); tick();
      reset = 1'b0;

      // 1: idle after reset, no download
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (core_reset !== 1'b1 || mem_en !== 1'b0 || ioctl_wait !== 1'b0) bad++;
      end
      chk("idle_100_cycles_bad", bad, 0);

      // 2: two bytes, index 0, memory always ready
      ioctl_download = 1'b1; ioctl_index = 8'd0;
      tick();
      exp_q.push_back({1'b1, 14'h0000, 8'h12});
      send_byte(25'h0, 8'h12, 0, n);
      chk("t2_wait_cycles_b0", n, 1);
      exp_q.push_back({1'b1, 14'h0001, 8'h34});
      send_byte(25'h1, 8'h34, 0, n);
      chk("t2_wait_cycles_b1", n, 1);
      chk("t2_dn_count", dn_count, 2);
      chk("t2_dn_err", dn_err, 0);
      chk("t2_core_reset_loading", core_reset, 1);
      ioctl_download = 1'b0;
      tick();
      wait_run(k);
      chk("t2_hold_cycles", k, 16);

      // 3: back-pressured byte while running: new download restarts the count
      ioctl_download = 1'b1;
      tick();
      chk("t3_count_cleared", dn_count, 0);
      chk("t3_core_reset", core_reset, 1);
      mem_ready = 1'b0;
      exp_q.push_back({1'b1, 14'h0010, 8'hAA});
      send_byte(25'h10, 8'hAA, 6, n);
      chk("t3_wait_cycles", n, 6);
      chk("t3_dn_count", dn_count, 1);

      // 4: out-of-range address is dropped
      send_byte(25'h4000, 8'h5A, 0, n);
      chk("t4_wait_cycles", n, 0);
      chk("t4_dn_err", dn_err, 1);
      chk("t4_dn_count", dn_count, 1);

      // 4b: download falls while the buffer is still full
      mem_ready = 1'b0;
      exp_q.push_back({1'b1, 14'h0011, 8'hBB});
      ioctl_addr = 25'h11; ioctl_dout = 8'hBB; ioctl_wr = 1'b1;
      tick();
      ioctl_wr = 1'b0; ioctl_download = 1'b0;
      tick(); tick(); tick();
      chk("t4b_wait_held", ioctl_wait, 1);
      chk("t4b_core_reset", core_reset, 1);
      mem_ready = 1'b1;
      tick();
      chk("t4b_dn_count", dn_count, 2);
      wait_run(k);
      chk("t4b_run", core_reset, 0);

      // 6: CPU write and download rise in the same cycle while running
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h20; cpu_din = 8'h55;
      ioctl_download = 1'b1; ioctl_index = 8'd0;
      exp_q.push_back({1'b1, 14'h0020, 8'h55});
      pre_ack = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (cpu_ack) pre_ack++;
      end
      chk("t6_dn_err_cleared", dn_err, 0);
      ioctl_download = 1'b0;
      k = 0;
      while (core_reset && k < 200) begin
         tick();
         k++;
         if (cpu_ack) pre_ack++;
      end
      chk("t6_ack_before_run", pre_ack, 0);
      acks = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (cpu_ack) begin
            acks++;
            cpu_req = 1'b0;
         end
      end
      chk("t6_ack_count", acks, 1);
      cpu_req = 1'b0;

      // reset in the middle of a download with a byte buffered
      ioctl_download = 1'b1;
      tick();
      mem_ready = 1'b0;
      ioctl_addr = 25'h30; ioctl_dout = 8'h99; ioctl_wr = 1'b1;
      tick();
      ioctl_wr = 1'b0;
      chk("rst_mid_wait_before", ioctl_wait, 1);
      #2 reset = 1'b1;
      #1;
      chk("rst_mid_wait", ioctl_wait, 0);
      chk("rst_mid_mem_en", mem_en, 0);
      chk("rst_mid_core_reset", core_reset, 1);
      ioctl_download = 1'b0; mem_ready = 1'b1;
      tick(); tick();
      reset = 1'b0;
      tick(); tick(); tick();
      chk("rst_mid_dn_count", dn_count, 0);

      // 5: foreign index download is ignored but still cycles the core reset
      ioctl_download = 1'b1; ioctl_index = 8'd3;
      tick();
      send_byte(25'h5, 8'h77, 0, n);
      chk("t5_wait_cycles", n, 0);
      ioctl_download = 1'b0;
      tick();
      wait_run(k);
      chk("t5_hold_cycles", k, 16);
      chk("t5_dn_count", dn_count, 0);

      tick(); tick();
      chk("queue_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
